mode_lap_stopwatch: RTL and testbench
=====================================

// Module: mode_lap_stopwatch
// PURPOSE
//  Stopwatch display mode with lap capture: BCD MM:SS:CC counter driven by the 100 Hz enable,
//  a circular buffer of LAP_DEPTH lap times, and a lap-review mode.
//  Sits beside the other watch modes; the LCD writer scans index 0..31 and latches out as ASCII.
//  Counts directly in BCD; no binary-to-BCD converters.
// PARAMETERS
//  LAP_DEPTH  4   lap entries stored, 1..9 (one ASCII digit)
//  MIN_MAX    59  last minute value before wrap, 1..99
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset
//  en_100hz   in   1  one-cycle tick at 100 Hz; advances counter when running
//  btn_start  in   1  one-cycle pulse (debounced upstream): start/stop toggle
//  btn_lap    in   1  one-cycle pulse: capture lap (RUN) / step review (HOLD)
//  btn_clr    in   1  one-cycle pulse: clear time and laps (ignored in RUN)
//  index      in   5  LCD character position, 0-15 line 1, 16-31 line 2
//  out        out  8  ASCII character for index, registered
//  running    out  1  1 in RUN
//  lap_count  out  4  valid lap entries, 0..LAP_DEPTH
//  ovf        out  1  sticky: counter wrapped since last clear
// BEHAVIOUR
//  Reset: state IDLE, time 00:00:00, laps empty, view_sel 0, out 8'h20, running 0, lap_count 0, ovf 0.
//  FSM: IDLE -start-> RUN; RUN -start-> HOLD; HOLD -start-> RUN; IDLE/HOLD -clr-> IDLE.
//   clr in RUN ignored. start and clr same cycle: clr wins in IDLE/HOLD, start wins in RUN.
//  Counter (RUN only, on en_100hz): CC 00..99 -> SS +1; SS 59 -> MM +1; MIN_MAX:59:99 -> 00:00:00 and ovf<=1.
//   Every digit pair stays valid BCD; no intermediate illegal value ever shown.
//  Lap (btn_lap in RUN): write time value held before this cycle's tick into slot wr_ptr.
//   wr_ptr wraps mod LAP_DEPTH; lap_count saturates at LAP_DEPTH; when full, oldest entry overwritten.
//   btn_lap in IDLE: ignored.
//  Review (btn_lap in HOLD): view_sel 0 = live time, 1..lap_count = stored laps, 1 = oldest.
//   Step view_sel +1; after lap_count wrap to 0. view_sel forced to 0 on entering RUN or IDLE.
//  clr: time, laps, lap_count, wr_ptr, view_sel and ovf all cleared in the same cycle.
//  Display: out updated every clk from index; one-cycle latency; non-listed indices give 8'h20.
//   0-3 "IDLE"/"RUN "/"HOLD"; 5-8 "LAPS"; 9 ':'; 10 '0'+lap_count; 12 'O' if ovf else ' '.
//   16 'L' if view_sel!=0 else 'T'; 17 '0'+view_sel or ' ' when 0.
//   19-20 MM; 21 ':'; 22-23 SS; 24 ':'; 25-26 CC. Time is the live counter or the selected lap.
//  running, lap_count, ovf registered, change the cycle after the causing event.
//  Reset asserted mid-run: everything returns to reset values immediately; no lap retained.
// STRUCTURE
//  Package mode_watch_pkg: state enum (IDLE/RUN/HOLD), ASCII constants (space, colon, '0', letters),
//   BCD time struct {mm_t,mm_o,ss_t,ss_o,cc_t,cc_o}.
//  Sub-module bcd_time_counter: clk, rst, en, clr -> BCD time + wrap pulse; parametrised by MIN_MAX.
//  Top holds FSM, lap RAM (register array), view mux and ASCII mux.
// TESTING
//  Start, 150 ticks, read index 19-26 -> "00:01:50"; index 0-3 -> "RUN "; running=1.
//  MIN_MAX=59, preload 59:59:98 via ticks, two ticks -> 00:00:00, ovf=1, index 12 -> 'O'.
//  Lap and tick same cycle at 00:00:42 -> stored lap 00:00:42, live 00:00:43.
//  LAP_DEPTH=4, six laps at CC=1..6 -> lap_count=4; HOLD review steps show laps 03,04,05,06 then live.
//  clr pulse in RUN -> no change; start then clr in HOLD -> IDLE, 00:00:00, lap_count 0, ovf 0.
//  rst low during RUN at 00:12:34 -> out 8'h20, time zero, laps empty, state IDLE immediately.

Source files
------------

// File: rtl/mode_watch_pkg.sv
// Shared types and ASCII constants for the stopwatch watch mode.
// Time is kept as six packed BCD digits so the display never needs a converter.
package mode_watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } sw_state_t;

  typedef struct packed {
    logic [3:0] mm_t;
    logic [3:0] mm_o;
    logic [3:0] ss_t;
    logic [3:0] ss_o;
    logic [3:0] cc_t;
    logic [3:0] cc_o;
  } bcd_time_t;

  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_L     = 8'h4C;
  localparam logic [7:0] ASC_T     = 8'h54;
  localparam logic [7:0] ASC_O     = 8'h4F;

  localparam logic [31:0] STR_IDLE = "IDLE";
  localparam logic [31:0] STR_RUN  = "RUN ";
  localparam logic [31:0] STR_HOLD = "HOLD";
  localparam logic [31:0] STR_LAPS = "LAPS";

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASC_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// MM:SS:CC counter kept directly in BCD; wraps after MIN_MAX:59:99 with a one-cycle wrap pulse.
// clr has priority over en.
module bcd_time_counter
  import mode_watch_pkg::*;
#(
  parameter int unsigned MIN_MAX = 59
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      clr,
  output bcd_time_t time_o,
  output logic      wrap_o
);

  localparam logic [3:0] MM_T_LAST = 4'(MIN_MAX / 10);
  localparam logic [3:0] MM_O_LAST = 4'(MIN_MAX % 10);

  bcd_time_t time_q, time_d;
  logic      cc_carry, ss_carry, mm_last;

  always_comb begin
    time_d   = time_q;
    cc_carry = (time_q.cc_t == 4'd9) && (time_q.cc_o == 4'd9);
    ss_carry = cc_carry && (time_q.ss_t == 4'd5) && (time_q.ss_o == 4'd9);
    mm_last  = (time_q.mm_t == MM_T_LAST) && (time_q.mm_o == MM_O_LAST);
    wrap_o   = en && !clr && ss_carry && mm_last;

    if (clr) begin
      time_d = '0;
    end else if (en) begin
      if (time_q.cc_o == 4'd9) begin
        time_d.cc_o = 4'd0;
        time_d.cc_t = (time_q.cc_t == 4'd9) ? 4'd0 : time_q.cc_t + 4'd1;
      end else begin
        time_d.cc_o = time_q.cc_o + 4'd1;
      end

      if (cc_carry) begin
        if (time_q.ss_o == 4'd9) begin
          time_d.ss_o = 4'd0;
          time_d.ss_t = (time_q.ss_t == 4'd5) ? 4'd0 : time_q.ss_t + 4'd1;
        end else begin
          time_d.ss_o = time_q.ss_o + 4'd1;
        end
      end

      if (ss_carry) begin
        if (mm_last) begin
          time_d.mm_t = 4'd0;
          time_d.mm_o = 4'd0;
        end else if (time_q.mm_o == 4'd9) begin
          time_d.mm_o = 4'd0;
          time_d.mm_t = time_q.mm_t + 4'd1;
        end else begin
          time_d.mm_o = time_q.mm_o + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_q <= '0;
    end else begin
      time_q <= time_d;
    end
  end

  assign time_o = time_q;

endmodule

// File: rtl/mode_lap_stopwatch.sv
// Stopwatch watch mode: start/stop/hold FSM, circular lap store, lap review and
// the ASCII character source scanned by the LCD writer.
module mode_lap_stopwatch
  import mode_watch_pkg::*;
#(
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned MIN_MAX   = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_100hz,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic [4:0] index,
  output logic [7:0] out,
  output logic       running,
  output logic [3:0] lap_count,
  output logic       ovf
);

  localparam int unsigned      PTR_W    = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int unsigned      SUM_W    = PTR_W + 1;
  localparam logic [3:0]       DEPTH_C  = 4'(LAP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LAP_DEPTH - 1);

  sw_state_t        state_q;
  bcd_time_t        live_time, disp_time;
  bcd_time_t        lap_q [LAP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_slot;
  logic [SUM_W-1:0] rd_sum;
  logic [3:0]       lap_count_q, view_sel_q;
  logic             running_q, ovf_q;
  logic             cnt_en, cnt_clr, cnt_wrap;
  logic [7:0]       out_q, char_d;
  logic [31:0]      state_str;

  // clr is a no-op while running, so it can drive the counter clear directly
  assign cnt_en  = (state_q == ST_RUN) && en_100hz;
  assign cnt_clr = btn_clr && (state_q != ST_RUN);

  bcd_time_counter #(
    .MIN_MAX(MIN_MAX)
  ) u_time (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .time_o(live_time),
    .wrap_o(cnt_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      running_q   <= 1'b0;
      wr_ptr_q    <= '0;
      lap_count_q <= '0;
      view_sel_q  <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < int'(LAP_DEPTH); i++) lap_q[i] <= '0;
    end else if (cnt_clr) begin
      state_q     <= ST_IDLE;
      running_q   <= 1'b0;
      wr_ptr_q    <= '0;
      lap_count_q <= '0;
      view_sel_q  <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < int'(LAP_DEPTH); i++) lap_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_start) begin
            state_q    <= ST_RUN;
            running_q  <= 1'b1;
            view_sel_q <= '0;
          end
        end
        ST_RUN: begin
          if (cnt_wrap) ovf_q <= 1'b1;
          if (btn_lap) begin
            // live_time is still the pre-tick value on a lap/tick collision
            lap_q[wr_ptr_q] <= live_time;
            wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            lap_count_q     <= (lap_count_q == DEPTH_C) ? DEPTH_C : lap_count_q + 4'd1;
          end
          if (btn_start) begin
            state_q   <= ST_HOLD;
            running_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (btn_start) begin
            state_q    <= ST_RUN;
            running_q  <= 1'b1;
            view_sel_q <= '0;
          end else if (btn_lap) begin
            view_sel_q <= (view_sel_q == lap_count_q) ? 4'd0 : view_sel_q + 4'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // view_sel 1 is the oldest entry; once the store is full the oldest sits at wr_ptr
  always_comb begin
    rd_sum = SUM_W'(view_sel_q - 4'd1);
    if (lap_count_q == DEPTH_C) rd_sum = rd_sum + SUM_W'(wr_ptr_q);
    if (rd_sum >= SUM_W'(LAP_DEPTH)) rd_sum = rd_sum - SUM_W'(LAP_DEPTH);
    rd_slot = PTR_W'(rd_sum);
  end

  assign disp_time = (view_sel_q == 4'd0) ? live_time : lap_q[rd_slot];

  always_comb begin
    state_str = STR_IDLE;
    case (state_q)
      ST_RUN:  state_str = STR_RUN;
      ST_HOLD: state_str = STR_HOLD;
      default: state_str = STR_IDLE;
    endcase

    char_d = ASC_SP;
    case (index)
      5'd0:    char_d = state_str[31:24];
      5'd1:    char_d = state_str[23:16];
      5'd2:    char_d = state_str[15:8];
      5'd3:    char_d = state_str[7:0];
      5'd5:    char_d = STR_LAPS[31:24];
      5'd6:    char_d = STR_LAPS[23:16];
      5'd7:    char_d = STR_LAPS[15:8];
      5'd8:    char_d = STR_LAPS[7:0];
      5'd9:    char_d = ASC_COLON;
      5'd10:   char_d = ascii_digit(lap_count_q);
      5'd12:   char_d = ovf_q ? ASC_O : ASC_SP;
      5'd16:   char_d = (view_sel_q != 4'd0) ? ASC_L : ASC_T;
      5'd17:   char_d = (view_sel_q != 4'd0) ? ascii_digit(view_sel_q) : ASC_SP;
      5'd19:   char_d = ascii_digit(disp_time.mm_t);
      5'd20:   char_d = ascii_digit(disp_time.mm_o);
      5'd21:   char_d = ASC_COLON;
      5'd22:   char_d = ascii_digit(disp_time.ss_t);
      5'd23:   char_d = ascii_digit(disp_time.ss_o);
      5'd24:   char_d = ASC_COLON;
      5'd25:   char_d = ascii_digit(disp_time.cc_t);
      5'd26:   char_d = ascii_digit(disp_time.cc_o);
      default: char_d = ASC_SP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= ASC_SP;
    end else begin
      out_q <= char_d;
    end
  end

  assign out       = out_q;
  assign running   = running_q;
  assign lap_count = lap_count_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mode_lap_stopwatch.sv
// Stopwatch mode bench: a centisecond/queue model predicts every output each cycle,
// directed scenarios pin the model, and a second instance with a short minute range covers wrap.
module tb_mode_lap_stopwatch;

  localparam int LAP_DEPTH = 4;
  localparam int MIN_MAX   = 59;
  localparam int MIN_MAX2  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_100hz = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clr = 1'b0;
  logic [4:0] index = 5'd0;
  logic [7:0] out, out2;
  logic       running, running2, ovf, ovf2;
  logic [3:0] lap_count, lap_count2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model: state 0 idle / 1 run / 2 hold, time in centiseconds, laps oldest first
  int         m_st, m_t, m_view;
  bit         m_ovf;
  int         m_laps[$];
  logic [7:0] exp_out;
  int         exp_run, exp_lc, exp_ovf;
  string      m_ln;

  always #5 clk = ~clk;

  mode_lap_stopwatch #(.LAP_DEPTH(LAP_DEPTH), .MIN_MAX(MIN_MAX)) dut (
    .clk(clk), .rst(rst), .en_100hz(en_100hz), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_clr(btn_clr), .index(index), .out(out), .running(running),
    .lap_count(lap_count), .ovf(ovf)
  );

  mode_lap_stopwatch #(.LAP_DEPTH(LAP_DEPTH), .MIN_MAX(MIN_MAX2)) dut2 (
    .clk(clk), .rst(rst), .en_100hz(en_100hz), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_clr(btn_clr), .index(index), .out(out2), .running(running2),
    .lap_count(lap_count2), .ovf(ovf2)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=\"%s\" required=\"%s\" at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    m_t = 0;
    m_laps.delete();
    m_view = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_reset();
    m_st = 0;
    model_clear();
    exp_out = 8'h20;
    exp_run = 0;
    exp_lc  = 0;
    exp_ovf = 0;
  endfunction

  function automatic string model_line();
    string st, o, vd, l1, l2;
    int tv;
    st = (m_st == 1) ? "RUN " : (m_st == 2) ? "HOLD" : "IDLE";
    o  = m_ovf ? "O" : " ";
    vd = (m_view == 0) ? "T " : $sformatf("L%0d", m_view);
    tv = (m_view == 0) ? m_t : m_laps[m_view - 1];
    l1 = $sformatf("%s LAPS:%0d %s   ", st, m_laps.size(), o);
    l2 = $sformatf("%s %02d:%02d:%02d     ", vd, tv / 6000, (tv / 100) % 60, tv % 100);
    return {l1, l2};
  endfunction

  function automatic void model_step();
    case (m_st)
      0: begin
        if (btn_clr) model_clear();
        else if (btn_start) begin m_st = 1; m_view = 0; end
      end
      1: begin
        if (btn_lap) begin
          m_laps.push_back(m_t);
          if (m_laps.size() > LAP_DEPTH) void'(m_laps.pop_front());
        end
        if (en_100hz) begin
          m_t++;
          if (m_t == (MIN_MAX + 1) * 6000) begin m_t = 0; m_ovf = 1'b1; end
        end
        if (btn_start) m_st = 2;
      end
      default: begin
        if (btn_clr) begin model_clear(); m_st = 0; end
        else if (btn_start) begin m_st = 1; m_view = 0; end
        else if (btn_lap) m_view = (m_view == m_laps.size()) ? 0 : m_view + 1;
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      m_ln = model_line();
      exp_out = m_ln[int'(index)];
      model_step();
      exp_run = (m_st == 1) ? 1 : 0;
      exp_lc  = m_laps.size();
      exp_ovf = m_ovf ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("out", int'(out), int'(exp_out));
      chk("running", int'(running), exp_run);
      chk("lap_count", int'(lap_count), exp_lc);
      chk("ovf", int'(ovf), exp_ovf);
      chk("running2", int'(running2), exp_run);
      chk("lap_count2", int'(lap_count2), exp_lc);
    end
  end

  task automatic pulse(input bit s, input bit l, input bit c, input bit t);
    @(negedge clk);
    btn_start = s; btn_lap = l; btn_clr = c; en_100hz = t;
    @(negedge clk);
    btn_start = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0; en_100hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    @(negedge clk);
    en_100hz = 1'b1;
    repeat (n) @(negedge clk);
    en_100hz = 1'b0;
  endtask

  task automatic read_str(input bit second, input int first, input int n, output string s);
    s = "";
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      index = 5'(first + i);
      @(negedge clk);
      s = $sformatf("%s%c", s, second ? out2 : out);
    end
  endtask

  initial begin
    string s;
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out), 32'h20);
    chk("rst_running", int'(running), 0);
    chk("rst_lap_count", int'(lap_count), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b1;
    cmp_en = 1'b1;
    read_str(0, 0, 4, s);  chk_s("idle_name", s, "IDLE");

    // start, 150 ticks
    pulse(1, 0, 0, 0);
    ticks(150);
    read_str(0, 19, 8, s); chk_s("time_150", s, "00:01:50");
    chk("model_t_150", m_t, 150);
    read_str(0, 0, 4, s);  chk_s("run_name", s, "RUN ");
    chk("running_run", int'(running), 1);

    // lap and tick in the same cycle
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    ticks(42);
    pulse(0, 1, 0, 1);
    chk("lap42_count", int'(lap_count), 1);
    chk("model_lap42", m_laps[0], 42);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    read_str(0, 16, 11, s); chk_s("review_lap42", s, "L1 00:00:42");
    pulse(0, 1, 0, 0);
    read_str(0, 16, 11, s); chk_s("review_live43", s, "T  00:00:43");

    // clr ignored in RUN, honoured in HOLD
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    chk("clr_run_running", int'(running), 1);
    chk("clr_run_laps", int'(lap_count), 1);
    read_str(0, 19, 8, s); chk_s("clr_run_time", s, "00:00:43");
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    read_str(0, 0, 4, s);  chk_s("clr_hold_name", s, "IDLE");
    read_str(0, 19, 8, s); chk_s("clr_hold_time", s, "00:00:00");
    chk("clr_hold_laps", int'(lap_count), 0);
    chk("clr_hold_ovf", int'(ovf), 0);

    // six laps into a four-deep store, then review
    pulse(1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      ticks(1);
      pulse(0, 1, 0, 0);
    end
    chk("six_laps_count", int'(lap_count), 4);
    chk("model_oldest", m_laps[0], 3);
    pulse(1, 0, 0, 0);
    read_str(0, 0, 11, s); chk_s("hold_line1", s, "HOLD LAPS:4");
    for (int v = 1; v <= 4; v++) begin
      pulse(0, 1, 0, 0);
      read_str(0, 16, 11, s);
      chk_s($sformatf("review_%0d", v), s, $sformatf("L%0d 00:00:%02d", v, v + 2));
    end
    pulse(0, 1, 0, 0);
    read_str(0, 16, 11, s); chk_s("review_back_live", s, "T  00:00:06");

    // wrap on the short-minute instance
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    ticks(11998);
    read_str(1, 19, 8, s); chk_s("wrap_pre98", s, "01:59:98");
    chk("ovf2_pre", int'(ovf2), 0);
    ticks(1);
    read_str(1, 19, 8, s); chk_s("wrap_pre99", s, "01:59:99");
    chk("ovf2_pre99", int'(ovf2), 0);
    ticks(1);
    read_str(1, 19, 8, s); chk_s("wrap_zero", s, "00:00:00");
    read_str(1, 12, 1, s); chk_s("wrap_ovf_char", s, "O");
    chk("ovf2_post", int'(ovf2), 1);
    read_str(0, 19, 8, s); chk_s("main_2min", s, "02:00:00");
    read_str(0, 12, 1, s); chk_s("main_no_ovf", s, " ");
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    chk("ovf2_cleared", int'(ovf2), 0);

    // randomized traffic against the model
    repeat (3000) begin
      @(negedge clk);
      en_100hz  = ($urandom_range(0, 99) < 30);
      btn_start = ($urandom_range(0, 99) < 4);
      btn_lap   = ($urandom_range(0, 99) < 12);
      btn_clr   = ($urandom_range(0, 99) < 4);
      index     = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    en_100hz = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;

    // asynchronous reset while running at 00:12:34
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    pulse(1, 0, 0, 0);
    ticks(1234);
    pulse(0, 1, 0, 0);
    read_str(0, 19, 8, s); chk_s("pre_rst_time", s, "00:12:34");
    chk("pre_rst_laps", int'(lap_count), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_out", int'(out), 32'h20);
    chk("arst_out2", int'(out2), 32'h20);
    chk("arst_running", int'(running), 0);
    chk("arst_laps", int'(lap_count), 0);
    chk("arst_ovf", int'(ovf), 0);
    @(negedge clk); rst = 1'b1;
    read_str(0, 0, 4, s);  chk_s("post_rst_name", s, "IDLE");
    read_str(0, 5, 6, s);  chk_s("post_rst_laps", s, "LAPS:0");
    read_str(0, 16, 11, s); chk_s("post_rst_time", s, "T  00:00:00");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
